call_ret_unit: RTL and testbench
================================

# call_ret_unit

Control-flow sequencer that sits directly upstream of the hardware return-address `stack`. It accepts CALL and RET requests from the decode stage and drives the stack's `push`/`pop`/`data_in` ports. It also captures the popped return address and issues a one-cycle program-counter load to the fetch stage. It detects stack overflow and underflow and holds the pipeline in a sticky fault state until software or test logic clears it.

## Interface
Parameters:
- `ADDR_WIDTH`, 8, program-counter width. Must equal the connected stack's `WIDTH`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset. Synchronous, active-high. Also drives the connected stack's `rst`.
- `call_req`  in  1  decode requests a CALL.
- `ret_req`  in  1  decode requests a RET.
- `pc_in`  in  ADDR_WIDTH  address of the CALL instruction.
- `call_target`  in  ADDR_WIDTH  CALL destination address.
- `ack`  out  1  one-cycle pulse: request accepted.
- `busy`  out  1  sequencer not idle. Decode must stall.
- `pc_load`  out  1  one-cycle pulse: fetch loads `pc_next`.
- `pc_next`  out  ADDR_WIDTH  new PC, valid only while `pc_load`=1, otherwise 0.
- `stk_push`  out  1  to stack `push`.
- `stk_pop`  out  1  to stack `pop`.
- `stk_data_in`  out  ADDR_WIDTH  to stack `data_in`.
- `stk_data_out`  in  ADDR_WIDTH  from stack `data_out`. Combinational; valid only while `stk_pop`=1 and stack non-empty.
- `stk_empty`  in  1  from stack `empty`.
- `stk_full`  in  1  from stack `full`.
- `fault`  out  1  sticky stack fault.
- `fault_code`  out  2  01 = overflow, 10 = underflow, 00 = none.
- `fault_clr`  in  1  clears the fault and returns the unit to IDLE.

## Operation
States: IDLE, PUSH, POP, LOAD, FAULT.

**IDLE**
- Requests are sampled only in IDLE.
- Priority is `call_req` over `ret_req`. A simultaneous RET is ignored, and decode must re-present it.
- On CALL:
  - If `stk_full`=1: go to FAULT, `fault_code`=01.
  - Otherwise: pulse `ack`, register `ret_addr = pc_in + 1` (modulo 2^ADDR_WIDTH, wraps 0xFF→0x00 at width 8), register `call_target`, and go to PUSH.
- On RET:
  - If `stk_empty`=1: go to FAULT, `fault_code`=10.
  - Otherwise: pulse `ack` and go to POP.
- No `ack` is issued on a faulting request.

**PUSH**
- `stk_push`=1 and `stk_data_in`=`ret_addr`.
- Load `target_reg` with the registered call target.
- Go to LOAD.

**POP**
- `stk_pop`=1.
- Capture `stk_data_out` into `target_reg` at the clock edge ending this cycle.
- Go to LOAD.

**LOAD**
- `pc_load`=1 and `pc_next`=`target_reg`.
- Go to IDLE.

**FAULT**
- `fault`=1, `busy`=1, `fault_code` held.
- No stack strobes and no `pc_load`.
- `fault_clr`=1 → go to IDLE, `fault` and `fault_code` clear to 0.

**General rules**
- `fault_clr` is ignored outside FAULT.
- `busy`=1 whenever state ≠ IDLE.
- `stk_push` and `stk_pop` are never both 1, and each is high for exactly one cycle per operation.
- `stk_data_in` is 0 when `stk_push`=0.
- Requests arriving while `busy`=1 are ignored. They are not queued.

## Timing
- Reset values: state IDLE; all outputs 0 (`ack`, `busy`, `pc_load`, `pc_next`, `stk_push`, `stk_pop`, `stk_data_in`, `fault`, `fault_code`); internal registers 0.
- CALL, acceptance at cycle 0:
  - cycle 1: `stk_push`, `busy`.
  - cycle 2: `pc_load`, `busy`.
  - cycle 3: IDLE, and a new request can be accepted.
- RET, acceptance at cycle 0:
  - cycle 1: `stk_pop`, `busy`.
  - cycle 2: `pc_load`, `busy`.
  - cycle 3: IDLE.
- Throughput: one CALL/RET every 3 cycles.
- Fault detection: `fault` and `busy` rise the cycle after the offending request is sampled.
- `rst` asserted in any state: the next cycle is IDLE with all outputs 0. An in-flight `pc_load` is suppressed, and no push/pop is issued after reset.
- `stk_full`/`stk_empty` are sampled only at acceptance. The stack is exclusively owned by this unit, so they cannot change before the strobe.

## Test plan
1. **Reset:** hold `rst` 2 cycles with `call_req`=1 → every output 0, no `ack`, stack empty.
2. **CALL:** `pc_in`=0x10, `call_target`=0x40 at cycle 0 → `ack` at cycle 0; cycle 1 `stk_push`=1 with `stk_data_in`=0x11; cycle 2 `pc_load`=1 with `pc_next`=0x40; `busy` high in cycles 1–2.
3. **RET after test 2:** `ret_req` at cycle 0 → cycle 1 `stk_pop`=1; cycle 2 `pc_load`=1 with `pc_next`=0x11; stack `empty`=1 afterwards.
4. **Wrap and nesting:** CALL with `pc_in`=0xFF → pushes 0x00. Follow with CALL `pc_in`=0x20 then two RETs → `pc_next` sequence 0x21, then 0x00.
5. **Faults** (stack DEPTH=4):
   - Four CALLs, then a fifth → no `ack`, no `stk_push`, `fault`=1, `fault_code`=01, `busy` stays high until `fault_clr`.
   - Drain with four RETs, then one more RET → `fault_code`=10.
6. **Conflicts:**
   - `call_req` and `ret_req` in the same cycle → only the CALL executes (push, no pop).
   - `rst` asserted during PUSH → no `pc_load` follows; state IDLE, outputs 0.

Source files
------------

// File: rtl/call_ret_unit.sv
// CALL/RET sequencer in front of the return-address stack: pushes return addresses,
// pops them back, issues a one-cycle PC load to fetch and latches stack over/underflow.
module call_ret_unit #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  call_req,
    input  logic                  ret_req,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic [ADDR_WIDTH-1:0] call_target,
    output logic                  ack,
    output logic                  busy,
    output logic                  pc_load,
    output logic [ADDR_WIDTH-1:0] pc_next,
    output logic                  stk_push,
    output logic                  stk_pop,
    output logic [ADDR_WIDTH-1:0] stk_data_in,
    input  logic [ADDR_WIDTH-1:0] stk_data_out,
    input  logic                  stk_empty,
    input  logic                  stk_full,
    output logic                  fault,
    output logic [1:0]            fault_code,
    input  logic                  fault_clr
);

    typedef enum logic [2:0] {StIdle, StPush, StPop, StLoad, StFault} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ret_addr_q, ret_addr_d;
    logic [ADDR_WIDTH-1:0] call_tgt_q, call_tgt_d;
    logic [ADDR_WIDTH-1:0] target_q, target_d;
    logic [1:0]            fault_code_q, fault_code_d;

    always_comb begin
        state_d      = state_q;
        ret_addr_d   = ret_addr_q;
        call_tgt_d   = call_tgt_q;
        target_d     = target_q;
        fault_code_d = fault_code_q;
        ack          = 1'b0;
        busy         = (state_q != StIdle);
        pc_load      = 1'b0;
        pc_next      = '0;
        stk_push     = 1'b0;
        stk_pop      = 1'b0;
        stk_data_in  = '0;
        fault        = 1'b0;
        fault_code   = 2'b00;

        unique case (state_q)
            StIdle: begin
                // CALL wins; a simultaneous RET is dropped and must be re-presented.
                if (call_req) begin
                    if (stk_full) begin
                        state_d      = StFault;
                        fault_code_d = 2'b01;
                    end else begin
                        ack        = 1'b1;
                        ret_addr_d = pc_in + ADDR_WIDTH'(1);
                        call_tgt_d = call_target;
                        state_d    = StPush;
                    end
                end else if (ret_req) begin
                    if (stk_empty) begin
                        state_d      = StFault;
                        fault_code_d = 2'b10;
                    end else begin
                        ack     = 1'b1;
                        state_d = StPop;
                    end
                end
            end
            StPush: begin
                stk_push    = 1'b1;
                stk_data_in = ret_addr_q;
                target_d    = call_tgt_q;
                state_d     = StLoad;
            end
            StPop: begin
                stk_pop  = 1'b1;
                target_d = stk_data_out;
                state_d  = StLoad;
            end
            StLoad: begin
                pc_load = 1'b1;
                pc_next = target_q;
                state_d = StIdle;
            end
            StFault: begin
                fault      = 1'b1;
                fault_code = fault_code_q;
                if (fault_clr) begin
                    state_d      = StIdle;
                    fault_code_d = 2'b00;
                end
            end
            default: state_d = StIdle;
        endcase

        // Reset silences every output in the same cycle so no strobe leaks out.
        if (rst) begin
            ack         = 1'b0;
            busy        = 1'b0;
            pc_load     = 1'b0;
            pc_next     = '0;
            stk_push    = 1'b0;
            stk_pop     = 1'b0;
            stk_data_in = '0;
            fault       = 1'b0;
            fault_code  = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            ret_addr_q   <= '0;
            call_tgt_q   <= '0;
            target_q     <= '0;
            fault_code_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            ret_addr_q   <= ret_addr_d;
            call_tgt_q   <= call_tgt_d;
            target_q     <= target_d;
            fault_code_q <= fault_code_d;
        end
    end

endmodule

// File: tb/tb_call_ret_unit.sv
// Scoreboard bench for call_ret_unit with a 4-deep behavioural return stack attached.
module tb_call_ret_unit;

    localparam int AW = 8;
    localparam logic [2:0] K_ACK = 3'd1, K_PUSH = 3'd2, K_POP = 3'd3, K_LOAD = 3'd4,
                           K_FAULT = 3'd5;

    typedef struct packed {
        logic [2:0]    kind;
        logic [AW-1:0] val;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst, call_req, ret_req, fault_clr;
    logic [AW-1:0] pc_in, call_target;
    logic          ack, busy, pc_load, stk_push, stk_pop, fault;
    logic [AW-1:0] pc_next, stk_data_in, stk_data_out;
    logic          stk_empty, stk_full;
    logic [1:0]    fault_code;

    logic [AW-1:0] mem [4];
    logic [2:0]    sp;
    logic [1:0]    top_idx;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    logic fault_prev = 1'b0;

    always #5 clk = ~clk;

    call_ret_unit #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .call_req     (call_req),
        .ret_req      (ret_req),
        .pc_in        (pc_in),
        .call_target  (call_target),
        .ack          (ack),
        .busy         (busy),
        .pc_load      (pc_load),
        .pc_next      (pc_next),
        .stk_push     (stk_push),
        .stk_pop      (stk_pop),
        .stk_data_in  (stk_data_in),
        .stk_data_out (stk_data_out),
        .stk_empty    (stk_empty),
        .stk_full     (stk_full),
        .fault        (fault),
        .fault_code   (fault_code),
        .fault_clr    (fault_clr)
    );

    // Return-address stack, DEPTH=4.
    assign stk_empty    = (sp == 3'd0);
    assign stk_full     = (sp == 3'd4);
    assign top_idx      = sp[1:0] - 2'd1;
    assign stk_data_out = stk_empty ? '0 : mem[top_idx];

    always @(posedge clk) begin
        if (rst) begin
            sp <= 3'd0;
        end else if (stk_push && !stk_full) begin
            mem[sp[1:0]] <= stk_data_in;
            sp           <= sp + 3'd1;
        end else if (stk_pop && !stk_empty) begin
            sp <= sp - 3'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic expect_ev(input logic [2:0] kind, input logic [AW-1:0] val);
        exp_q.push_back({kind, val});
    endtask

    task automatic check_ev(input string name, input logic [2:0] kind, input logic [AW-1:0] val);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: unexpected event kind %0d val 0x%0h, expected none at %0t",
                     name, kind, val, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == kind && e.val == val) n_pass++;
            else $display("FAIL %s: got kind %0d val 0x%0h, expected kind %0d val 0x%0h at %0t",
                          name, kind, val, e.kind, e.val, $time);
        end
    endtask

    // Monitor: every output event is matched against the scoreboard in order.
    always @(negedge clk) begin
        if (stk_push && stk_pop) check_ev("push_pop_both", 3'd7, '0);
        if (ack)                 check_ev("ack", K_ACK, '0);
        if (stk_push)            check_ev("push", K_PUSH, stk_data_in);
        if (stk_pop)             check_ev("pop", K_POP, '0);
        if (pc_load)             check_ev("load", K_LOAD, pc_next);
        if (fault && !fault_prev) check_ev("fault", K_FAULT, {6'd0, fault_code});
        fault_prev = fault;
    end

    function automatic logic [23:0] outs();
        return {ack, busy, pc_load, pc_next, stk_push, stk_pop, stk_data_in, fault, fault_code};
    endfunction

    task automatic do_call(input logic [AW-1:0] pc, input logic [AW-1:0] tgt,
                           input logic [AW-1:0] exp_ret, input logic ok, input logic with_ret);
        if (ok) begin
            expect_ev(K_ACK, '0);
            expect_ev(K_PUSH, exp_ret);
            expect_ev(K_LOAD, tgt);
        end else begin
            expect_ev(K_FAULT, 8'h01);
        end
        call_req = 1'b1; ret_req = with_ret; pc_in = pc; call_target = tgt;
        @(negedge clk); chk("busy_c0", {31'd0, busy}, 32'd0);
        @(posedge clk); #1; call_req = 1'b0; ret_req = 1'b0;
        @(negedge clk); chk("busy_c1", {31'd0, busy}, 32'd1);
        if (ok) begin
            @(posedge clk); #1;
            @(negedge clk); chk("busy_c2", {31'd0, busy}, 32'd1);
            @(posedge clk); #1;
        end else begin
            chk("call_fault", {30'd0, fault_code}, 32'd1);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_ret(input logic [AW-1:0] exp_pc, input logic ok);
        if (ok) begin
            expect_ev(K_ACK, '0);
            expect_ev(K_POP, '0);
            expect_ev(K_LOAD, exp_pc);
        end else begin
            expect_ev(K_FAULT, 8'h02);
        end
        ret_req = 1'b1;
        @(posedge clk); #1; ret_req = 1'b0;
        @(negedge clk); chk("ret_busy_c1", {31'd0, busy}, 32'd1);
        if (ok) begin
            @(posedge clk); #1;
            @(negedge clk); chk("ret_busy_c2", {31'd0, busy}, 32'd1);
            @(posedge clk); #1;
        end else begin
            chk("ret_fault", {30'd0, fault_code}, 32'd2);
            @(posedge clk); #1;
        end
    endtask

    task automatic clear_fault();
        fault_clr = 1'b1;
        @(posedge clk); #1; fault_clr = 1'b0;
        @(negedge clk);
        chk("clr_fault", {31'd0, fault}, 32'd0);
        chk("clr_code", {30'd0, fault_code}, 32'd0);
        chk("clr_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; call_req = 1'b1; ret_req = 1'b0; fault_clr = 1'b0;
        pc_in = 8'h10; call_target = 8'h40;

        // Reset held with a pending CALL.
        repeat (2) begin
            @(negedge clk);
            chk("rst_outs", {8'd0, outs()}, 32'd0);
            @(posedge clk); #1;
        end
        chk("rst_empty", {31'd0, stk_empty}, 32'd1);
        rst = 1'b0; call_req = 1'b0;

        // Basic CALL then RET.
        do_call(8'h10, 8'h40, 8'h11, 1'b1, 1'b0);
        do_ret(8'h11, 1'b1);
        chk("ret_empty", {31'd0, stk_empty}, 32'd1);

        // Return-address wrap and nesting.
        do_call(8'hFF, 8'h80, 8'h00, 1'b1, 1'b0);
        do_call(8'h20, 8'h90, 8'h21, 1'b1, 1'b0);
        do_ret(8'h21, 1'b1);
        do_ret(8'h00, 1'b1);
        chk("nest_empty", {31'd0, stk_empty}, 32'd1);

        // Overflow: fifth CALL faults; requests during the fault are ignored.
        do_call(8'h01, 8'hA1, 8'h02, 1'b1, 1'b0);
        do_call(8'h02, 8'hA2, 8'h03, 1'b1, 1'b0);
        do_call(8'h03, 8'hA3, 8'h04, 1'b1, 1'b0);
        do_call(8'h04, 8'hA4, 8'h05, 1'b1, 1'b0);
        do_call(8'h05, 8'hA5, 8'h06, 1'b0, 1'b0);
        call_req = 1'b1; ret_req = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("fault_hold", {29'd0, busy, fault, fault_code[0]}, 32'd7);
            @(posedge clk); #1;
        end
        call_req = 1'b0; ret_req = 1'b0;
        clear_fault();

        // Drain, then underflow.
        do_ret(8'h05, 1'b1);
        do_ret(8'h04, 1'b1);
        do_ret(8'h03, 1'b1);
        do_ret(8'h02, 1'b1);
        do_ret(8'h00, 1'b0);
        clear_fault();

        // Simultaneous CALL and RET: only the CALL runs.
        do_call(8'h40, 8'hC0, 8'h41, 1'b1, 1'b1);
        chk("conflict_depth", {29'd0, sp}, 32'd1);

        // Reset during PUSH: no push, no pc_load afterwards.
        expect_ev(K_ACK, '0);
        call_req = 1'b1; pc_in = 8'h30; call_target = 8'hD0;
        @(posedge clk); #1; call_req = 1'b0; rst = 1'b1;
        @(negedge clk); chk("rst_push_outs", {8'd0, outs()}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk); chk("rst_after_outs", {8'd0, outs()}, 32'd0);
        chk("rst_after_empty", {31'd0, stk_empty}, 32'd1);
        @(posedge clk); #1;

        do_call(8'h50, 8'h60, 8'h51, 1'b1, 1'b0);
        do_ret(8'h51, 1'b1);

        repeat (3) @(posedge clk);
        chk("sb_drain", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
